// File: rtl/mul_div_ctrl.sv
// HI/LO multiply/divide sequencer: MULT/MULTU finish after MUL_CYCLES+1 cycles, DIV/DIVU after 33.
// stall holds EX while busy; there is no backpressure on done. cancel aborts the operation in flight.
module mul_div_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [4:0]  count;
    logic [31:0] a_reg, b_reg, rem, quo;
    logic        sign_a, sign_b, div_zero;

    logic        in_sign_a;
    logic [31:0] abs_a_in, abs_b;
    logic [63:0] ext_a, ext_b, product;
    logic [32:0] rem_sh, diff;
    logic [31:0] rem_nxt, quo_nxt, q_fix, r_fix;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                accept = start & ~cancel;
                stall  = accept;
                if (accept) state_nxt = op[1] ? DIV : MUL;
            end
            MUL, DIV: begin
                stall = ~cancel;
                if (cancel)           state_nxt = IDLE;
                else if (count == '0) state_nxt = DONE;
            end
            DONE: begin
                accept    = start & ~cancel;
                stall     = accept;
                done      = ~cancel;
                state_nxt = accept ? (op[1] ? DIV : MUL) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sign-extend only for signed ops so one 64-bit multiply covers MULT and MULTU.
    always_comb begin
        ext_a     = {{32{sign_a}}, a_reg};
        ext_b     = {{32{sign_b}}, b_reg};
        product   = ext_a * ext_b;
        in_sign_a = src_a[31] & ~op[0];
        abs_a_in  = in_sign_a ? -src_a : src_a;
        abs_b     = sign_b ? -b_reg : b_reg;
        rem_sh    = {rem, quo[31]};
        diff      = rem_sh - {1'b0, abs_b};
        if (diff[32]) begin
            rem_nxt = rem_sh[31:0];
            quo_nxt = {quo[30:0], 1'b0};
        end else begin
            rem_nxt = diff[31:0];
            quo_nxt = {quo[30:0], 1'b1};
        end
        q_fix = (sign_a ^ sign_b) ? -quo_nxt : quo_nxt;
        r_fix = sign_a ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            rem      <= '0;
            quo      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_reg    <= src_a;
                b_reg    <= src_b;
                sign_a   <= in_sign_a;
                sign_b   <= src_b[31] & ~op[0];
                div_zero <= (src_b == '0);
                rem      <= '0;
                quo      <= abs_a_in;
                count    <= op[1] ? 5'd31 : 5'(MUL_CYCLES - 1);
            end else if (state == MUL && !cancel) begin
                if (count == '0) begin
                    hi_out <= product[63:32];
                    lo_out <= product[31:0];
                end else begin
                    count <= count - 5'd1;
                end
            end else if (state == DIV && !cancel) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                // Divide by zero runs the full iteration count but forces the architected result.
                if (count == '0) begin
                    hi_out <= div_zero ? a_reg : r_fix;
                    lo_out <= div_zero ? 32'hFFFF_FFFF : q_fix;
                end else begin
                    count <= count - 5'd1;
                end
            end
        end
    end

endmodule
